axil_cfg_arbiter: RTL and testbench

- Shares one downstream AXI-Lite master port between N_MST upstream AXI-Lite requesters.
- Typical requesters are the host configuration path and the dataflow controller's SAURIA register sequencer; the downstream target is SAURIA's configuration slave.
- Read and write channels are arbitrated independently, each round-robin, with one outstanding transaction per channel.

---
 rtl/axil_cfg_arbiter_if.sv | 30 +++
 rtl/axil_cfg_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_axil_cfg_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cfg_arbiter_if.sv
// AXI-Lite bundle carrying N_PORT independent channels side by side.
// The arbiter uses an N_MST-wide bundle upstream and a 1-wide bundle downstream.
interface axil_cfg_arbiter_if #(
  parameter int N_PORT     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_PORT-1:0]                     awvalid, awready;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0]     awaddr;
  logic [N_PORT-1:0]                     wvalid, wready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]     wdata;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]   wstrb;
  logic [N_PORT-1:0]                     bvalid, bready;
  logic [N_PORT-1:0][1:0]                bresp;
  logic [N_PORT-1:0]                     arvalid, arready;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0]     araddr;
  logic [N_PORT-1:0]                     rvalid, rready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]     rdata;
  logic [N_PORT-1:0][1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_cfg_arbiter.sv
// Round-robin arbiter sharing one downstream AXI-Lite port between N_MST
// requesters. Read and write channels arbitrate independently, one
// outstanding transaction each.

// Per-requester return path: forwards downstream readies/responses only while
// this requester owns the relevant phase, zero otherwise.
module axil_cfg_arb_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aw_sel,
  input  logic                  w_sel,
  input  logic                  b_sel,
  input  logic                  ar_sel,
  input  logic                  r_sel,
  input  logic                  ds_awready,
  input  logic                  ds_wready,
  input  logic                  ds_bvalid,
  input  logic [1:0]            ds_bresp,
  input  logic                  ds_arready,
  input  logic                  ds_rvalid,
  input  logic [DATA_WIDTH-1:0] ds_rdata,
  input  logic [1:0]            ds_rresp,
  output logic                  awready,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  output logic                  arready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp
);
  assign awready = aw_sel & ds_awready;
  assign wready  = w_sel & ds_wready;
  assign bvalid  = b_sel & ds_bvalid;
  assign bresp   = b_sel ? ds_bresp : 2'b00;
  assign arready = ar_sel & ds_arready;
  assign rvalid  = r_sel & ds_rvalid;
  assign rdata   = r_sel ? ds_rdata : '0;
  assign rresp   = r_sel ? ds_rresp : 2'b00;
endmodule

module axil_cfg_arbiter #(
  parameter int N_MST      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  axil_cfg_arbiter_if.slave          s,
  axil_cfg_arbiter_if.master         m,
  output logic                       wr_busy,
  output logic                       rd_busy,
  output logic [$clog2(N_MST)-1:0]   wr_gnt,
  output logic [$clog2(N_MST)-1:0]   rd_gnt
);
  localparam int GW = $clog2(N_MST);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  // First requester at or after ptr, wrapping modulo N_MST.
  function automatic logic [GW-1:0] rr_pick(input logic [N_MST-1:0] req,
                                            input logic [GW-1:0]    ptr);
    int j;
    rr_pick = ptr;
    for (int k = N_MST - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_MST;
      if (req[j]) rr_pick = GW'(j);
    end
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    rr_next = GW'((int'(g) + 1) % N_MST);
  endfunction

  // ---------------- write channel ----------------
  wr_state_t        wr_state, wr_state_n;
  logic [GW-1:0]    wr_ptr, wr_ptr_n, wr_gnt_n;
  logic             aw_done, aw_done_n, w_done, w_done_n;
  logic [N_MST-1:0] wr_req;

  // AW without W is not a request: both must be offered together.
  assign wr_req = s.awvalid & s.wvalid;

  // Write state, grant, round-robin pointer and per-channel done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_ptr   <= '0;
      wr_gnt   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wr_ptr   <= wr_ptr_n;
      wr_gnt   <= wr_gnt_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
    end
  end

  // Write next-state and downstream valid/ready generation.
  always_comb begin
    wr_state_n = wr_state;
    wr_ptr_n   = wr_ptr;
    wr_gnt_n   = wr_gnt;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    m.awvalid  = '0;
    m.wvalid   = '0;
    m.bready   = '0;
    case (wr_state)
      W_IDLE: begin
        if (|wr_req) begin
          wr_gnt_n   = rr_pick(wr_req, wr_ptr);
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
          wr_state_n = W_ADDR;
        end
      end
      W_ADDR: begin
        m.awvalid[0] = !aw_done;
        m.wvalid[0]  = !w_done;
        aw_done_n    = aw_done | m.awready[0];
        w_done_n     = w_done | m.wready[0];
        if (aw_done_n && w_done_n) wr_state_n = W_RESP;
      end
      W_RESP: begin
        m.bready[0] = s.bready[wr_gnt];
        if (m.bvalid[0] && s.bready[wr_gnt]) begin
          wr_ptr_n   = rr_next(wr_gnt);
          wr_state_n = W_IDLE;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0]   awaddr_mux;
  logic [DATA_WIDTH-1:0]   wdata_mux;
  logic [DATA_WIDTH/8-1:0] wstrb_mux;
  assign awaddr_mux  = s.awaddr[wr_gnt];
  assign wdata_mux   = s.wdata[wr_gnt];
  assign wstrb_mux   = s.wstrb[wr_gnt];
  assign m.awaddr[0] = awaddr_mux;
  assign m.wdata[0]  = wdata_mux;
  assign m.wstrb[0]  = wstrb_mux;
  assign wr_busy     = (wr_state != W_IDLE);

  // ---------------- read channel ----------------
  rd_state_t     rd_state, rd_state_n;
  logic [GW-1:0] rd_ptr, rd_ptr_n, rd_gnt_n;

  // Read state, grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      rd_gnt   <= '0;
    end else begin
      rd_state <= rd_state_n;
      rd_ptr   <= rd_ptr_n;
      rd_gnt   <= rd_gnt_n;
    end
  end

  // Read next-state and downstream valid/ready generation.
  always_comb begin
    rd_state_n = rd_state;
    rd_ptr_n   = rd_ptr;
    rd_gnt_n   = rd_gnt;
    m.arvalid  = '0;
    m.rready   = '0;
    case (rd_state)
      R_IDLE: begin
        if (|s.arvalid) begin
          rd_gnt_n   = rr_pick(s.arvalid, rd_ptr);
          rd_state_n = R_ADDR;
        end
      end
      R_ADDR: begin
        m.arvalid[0] = 1'b1;
        if (m.arready[0]) rd_state_n = R_DATA;
      end
      R_DATA: begin
        m.rready[0] = s.rready[rd_gnt];
        if (m.rvalid[0] && s.rready[rd_gnt]) begin
          rd_ptr_n   = rr_next(rd_gnt);
          rd_state_n = R_IDLE;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0] araddr_mux;
  assign araddr_mux  = s.araddr[rd_gnt];
  assign m.araddr[0] = araddr_mux;
  assign rd_busy     = (rd_state != R_IDLE);

  // ---------------- per-requester return paths ----------------
  logic [N_MST-1:0]                 l_awready, l_wready, l_bvalid, l_arready, l_rvalid;
  logic [N_MST-1:0][1:0]            l_bresp, l_rresp;
  logic [N_MST-1:0][DATA_WIDTH-1:0] l_rdata;

  for (genvar i = 0; i < N_MST; i++) begin : g_lane
    logic wsel, rsel;
    assign wsel = (wr_gnt == GW'(i));
    assign rsel = (rd_gnt == GW'(i));
    axil_cfg_arb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .aw_sel     (wsel && wr_state == W_ADDR && !aw_done),
      .w_sel      (wsel && wr_state == W_ADDR && !w_done),
      .b_sel      (wsel && wr_state == W_RESP),
      .ar_sel     (rsel && rd_state == R_ADDR),
      .r_sel      (rsel && rd_state == R_DATA),
      .ds_awready (m.awready[0]),
      .ds_wready  (m.wready[0]),
      .ds_bvalid  (m.bvalid[0]),
      .ds_bresp   (m.bresp[0]),
      .ds_arready (m.arready[0]),
      .ds_rvalid  (m.rvalid[0]),
      .ds_rdata   (m.rdata[0]),
      .ds_rresp   (m.rresp[0]),
      .awready    (l_awready[i]),
      .wready     (l_wready[i]),
      .bvalid     (l_bvalid[i]),
      .bresp      (l_bresp[i]),
      .arready    (l_arready[i]),
      .rvalid     (l_rvalid[i]),
      .rdata      (l_rdata[i]),
      .rresp      (l_rresp[i])
    );
  end

  assign s.awready = l_awready;
  assign s.wready  = l_wready;
  assign s.bvalid  = l_bvalid;
  assign s.bresp   = l_bresp;
  assign s.arready = l_arready;
  assign s.rvalid  = l_rvalid;
  assign s.rdata   = l_rdata;
  assign s.rresp   = l_rresp;
endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// Bench for axil_cfg_arbiter: directed requester traffic, a reactive
// downstream slave, and a scoreboard monitor popping expected beats.
module tb_axil_cfg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       wr_busy, rd_busy;
  logic [0:0] wr_gnt, rd_gnt;

  int n_cmp = 0;
  int n_err = 0;
  int b_cnt0 = 0, b_cnt1 = 0;

  logic [1:0]  sl_bresp = 2'd0;
  logic [1:0]  sl_rresp = 2'd0;
  logic [31:0] sl_rdata = 32'h0;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_b0[$], exp_b1[$];
  logic [33:0] exp_r0[$], exp_r1[$];

  axil_cfg_arbiter_if #(.N_PORT(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) up ();
  axil_cfg_arbiter_if #(.N_PORT(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dn ();

  axil_cfg_arbiter #(.N_MST(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s(up), .m(dn),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out, required completion within 100 cycles", nm);
  endtask

  // Downstream slave: B one cycle after both AW and W land, R after AR.
  logic aw_got, w_got, aw_nxt, w_nxt;
  assign aw_nxt = aw_got | (dn.awvalid[0] & dn.awready[0]);
  assign w_nxt  = w_got | (dn.wvalid[0] & dn.wready[0]);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dn.bvalid <= '0; dn.bresp <= '0; dn.rvalid <= '0; dn.rdata <= '0; dn.rresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (dn.bvalid[0] && dn.bready[0]) dn.bvalid[0] <= 1'b0;
      else if (!dn.bvalid[0] && aw_nxt && w_nxt) begin
        dn.bvalid[0] <= 1'b1; dn.bresp[0] <= sl_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_nxt; w_got <= w_nxt;
      end
      if (dn.rvalid[0] && dn.rready[0]) dn.rvalid[0] <= 1'b0;
      else if (!dn.rvalid[0] && dn.arvalid[0] && dn.arready[0]) begin
        dn.rvalid[0] <= 1'b1; dn.rdata[0] <= sl_rdata; dn.rresp[0] <= sl_rresp;
      end
    end
  end

  // Scoreboard monitor: every handshake pops and compares one expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (dn.awvalid[0] && dn.awready[0]) begin
        if (exp_aw.size() == 0) begin n_cmp++; n_err++; $display("FAIL aw_extra: got addr %0h, required none", dn.awaddr[0]); end
        else check("aw_addr", dn.awaddr[0], exp_aw.pop_front());
      end
      if (dn.wvalid[0] && dn.wready[0]) begin
        if (exp_w.size() == 0) begin n_cmp++; n_err++; $display("FAIL w_extra: got data %0h, required none", dn.wdata[0]); end
        else check("w_strb_data", {dn.wstrb[0], dn.wdata[0]}, exp_w.pop_front());
      end
      if (dn.arvalid[0] && dn.arready[0]) begin
        if (exp_ar.size() == 0) begin n_cmp++; n_err++; $display("FAIL ar_extra: got addr %0h, required none", dn.araddr[0]); end
        else check("ar_addr", dn.araddr[0], exp_ar.pop_front());
      end
      if (up.bvalid[0] && up.bready[0]) begin
        b_cnt0++;
        if (exp_b0.size() == 0) begin n_cmp++; n_err++; $display("FAIL b0_extra: got bresp %0h, required none", up.bresp[0]); end
        else check("b0_resp", up.bresp[0], exp_b0.pop_front());
        check("b0_isolation", {up.bvalid[1], up.bresp[1]}, 0);
      end
      if (up.bvalid[1] && up.bready[1]) begin
        b_cnt1++;
        if (exp_b1.size() == 0) begin n_cmp++; n_err++; $display("FAIL b1_extra: got bresp %0h, required none", up.bresp[1]); end
        else check("b1_resp", up.bresp[1], exp_b1.pop_front());
        check("b1_isolation", {up.bvalid[0], up.bresp[0]}, 0);
      end
      if (up.rvalid[0] && up.rready[0]) begin
        if (exp_r0.size() == 0) begin n_cmp++; n_err++; $display("FAIL r0_extra: got rdata %0h, required none", up.rdata[0]); end
        else check("r0_resp_data", {up.rresp[0], up.rdata[0]}, exp_r0.pop_front());
        check("r0_isolation", {up.rvalid[1], up.rresp[1], up.rdata[1]}, 0);
      end
      if (up.rvalid[1] && up.rready[1]) begin
        if (exp_r1.size() == 0) begin n_cmp++; n_err++; $display("FAIL r1_extra: got rdata %0h, required none", up.rdata[1]); end
        else check("r1_resp_data", {up.rresp[1], up.rdata[1]}, exp_r1.pop_front());
        check("r1_isolation", {up.rvalid[0], up.rresp[0], up.rdata[0]}, 0);
      end
    end
  end

  // Requester write: offer AW+W, drop each after its handshake, wait for B.
  task automatic wr_req(input int i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input logic [1:0] eb);
    bit awd, wd, h_aw, h_w;
    int t;
    if (i == 0) exp_b0.push_back(eb); else exp_b1.push_back(eb);
    up.awaddr[i] = a; up.wdata[i] = d; up.wstrb[i] = st;
    up.awvalid[i] = 1'b1; up.wvalid[i] = 1'b1;
    awd = 0; wd = 0; t = 0;
    while (!(awd && wd) && t < 100) begin
      @(negedge clk); h_aw = up.awready[i]; h_w = up.wready[i];
      @(posedge clk); #1; t++;
      if (h_aw) begin awd = 1; up.awvalid[i] = 1'b0; end
      if (h_w)  begin wd = 1;  up.wvalid[i] = 1'b0; end
    end
    if (!(awd && wd)) begin
      fail_to("wr_addr_phase"); up.awvalid[i] = 1'b0; up.wvalid[i] = 1'b0;
      return;
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!up.bvalid[i] && t < 100);
    if (!up.bvalid[i]) fail_to("wr_b_phase");
    else begin @(posedge clk); #1; end
  endtask

  // Requester read; with rdly>0 rready is held low for rdly cycles of rvalid.
  task automatic rd_req(input int i, input logic [31:0] a, input int rdly);
    bit got;
    int t;
    up.araddr[i] = a; up.arvalid[i] = 1'b1; got = 0; t = 0;
    while (!got && t < 100) begin
      @(negedge clk); got = up.arready[i];
      @(posedge clk); #1; t++;
    end
    up.arvalid[i] = 1'b0;
    if (!got) begin fail_to("rd_addr_phase"); return; end
    t = 0;
    do begin @(negedge clk); t++; end while (!up.rvalid[i] && t < 100);
    if (!up.rvalid[i]) begin fail_to("rd_data_phase"); return; end
    for (int k = 0; k < rdly; k++) begin
      check("bp_m_rready_low", dn.rready[0], 0);
      check("bp_rd_busy", rd_busy, 1);
      @(posedge clk); #1;
      if (k == rdly - 1) up.rready[i] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up.awvalid = '0; up.wvalid = '0; up.arvalid = '0;
    up.bready = '1; up.rready = '1;
    up.awaddr = '0; up.wdata = '0; up.wstrb = '0; up.araddr = '0;
    dn.awready = 1'b1; dn.wready = 1'b1; dn.arready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_gnt", {wr_busy, rd_busy, wr_gnt, rd_gnt}, 0);
    check("rst_up_ctrl", {up.awready, up.wready, up.bvalid, up.arready, up.rvalid}, 0);
    check("rst_up_data", {up.bresp, up.rresp, up.rdata[0]}, 0);
    check("rst_dn_ctrl", {dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single write from r0.
    exp_aw.push_back(32'h10); exp_w.push_back({4'hF, 32'hDEADBEEF});
    fork
      wr_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 2'd0);
      begin
        @(negedge clk); check("single_arb_no_dn_valid", dn.awvalid[0], 0);
        @(negedge clk); check("single_dn_valids_lat1", {dn.awvalid[0], dn.wvalid[0]}, 2'b11);
        check("single_busy_gnt", {wr_busy, wr_gnt}, 2'b10);
        check("single_r1_untouched", {up.awready[1], up.wready[1]}, 0);
      end
    join
    @(negedge clk); check("single_idle_after", wr_busy, 0);

    // Contention: both requesters write back to back, 3 each.
    do_reset();
    b_cnt0 = 0; b_cnt1 = 0;
    for (int k = 0; k < 3; k++) begin
      exp_aw.push_back(32'h100); exp_w.push_back({4'hF, 32'hA0 + k});
      exp_aw.push_back(32'h200); exp_w.push_back({4'hF, 32'hB0 + k});
    end
    fork
      for (int k = 0; k < 3; k++) wr_req(0, 32'h100, 32'hA0 + k, 4'hF, 2'd0);
      for (int k = 0; k < 3; k++) wr_req(1, 32'h200, 32'hB0 + k, 4'hF, 2'd0);
    join
    check("cont_b0_count", b_cnt0, 3);
    check("cont_b1_count", b_cnt1, 3);

    // Split AW/W with SLVERR passthrough.
    sl_bresp = 2'd2;
    exp_aw.push_back(32'h40); exp_w.push_back({4'h3, 32'h11223344});
    dn.awready = 1'b0; dn.wready = 1'b0;
    fork
      wr_req(0, 32'h40, 32'h11223344, 4'h3, 2'd2);
      begin
        int naw, nw;
        naw = 0; nw = 0;
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          dn.awready = (c == 2); dn.wready = (c == 5);
          @(negedge clk);
          naw += int'(up.awready[0]); nw += int'(up.wready[0]);
          if (c == 3 || c == 4) check("split_aw_not_repeated", {dn.awvalid[0], dn.wvalid[0]}, 2'b01);
          if (c == 4 || c == 5) check("split_no_resp_before_w", dn.bready[0], 0);
          if (c == 6) check("split_resp_after_w", dn.bready[0], 1);
        end
        check("split_awready_pulses", naw, 1);
        check("split_wready_pulses", nw, 1);
      end
    join
    dn.awready = 1'b1; dn.wready = 1'b1; sl_bresp = 2'd0;

    // Concurrent read (r0) and write (r1).
    sl_rdata = 32'hC0000001; sl_rresp = 2'd0;
    exp_ar.push_back(32'h14); exp_r0.push_back({2'd0, 32'hC0000001});
    exp_aw.push_back(32'h18); exp_w.push_back({4'h3, 32'h5A5A5A5A});
    fork
      rd_req(0, 32'h14, 0);
      wr_req(1, 32'h18, 32'h5A5A5A5A, 4'h3, 2'd0);
      begin
        @(negedge clk); @(negedge clk);
        check("conc_both_busy", {wr_busy, rd_busy}, 2'b11);
      end
    join
    @(negedge clk); check("conc_idle_after", {wr_busy, rd_busy}, 0);

    // Read backpressure on r1 with SLVERR.
    sl_rdata = 32'h0BADF00D; sl_rresp = 2'd2;
    exp_ar.push_back(32'h24); exp_r1.push_back({2'd2, 32'h0BADF00D});
    up.rready[1] = 1'b0;
    rd_req(1, 32'h24, 10);
    @(negedge clk); check("bp_rd_gnt_held", {rd_busy, rd_gnt}, 2'b01);

    // Reset while r0 sits in the address phase.
    @(posedge clk); #1;
    dn.awready = 1'b0; dn.wready = 1'b0;
    up.awaddr[0] = 32'h80; up.awvalid[0] = 1'b1; up.wvalid[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check("rstmid_pre_awvalid", dn.awvalid[0], 1);
    #2 rst = 1'b1;
    #1 check("rstmid_dn_zero", {dn.awvalid, dn.wvalid, dn.bready, dn.arvalid, dn.rready}, 0);
    check("rstmid_up_zero", {up.awready, up.wready, up.bvalid, wr_busy}, 0);
    up.awvalid[0] = 1'b0; up.wvalid[0] = 1'b0;
    dn.awready = 1'b1; dn.wready = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    exp_aw.push_back(32'h300); exp_w.push_back({4'hF, 32'h33});
    fork
      wr_req(1, 32'h300, 32'h33, 4'hF, 2'd0);
      begin
        @(negedge clk); @(negedge clk);
        check("rstmid_r1_granted", {wr_busy, wr_gnt}, 2'b11);
      end
    join
    @(negedge clk); check("gnt_held_in_idle", {wr_busy, wr_gnt}, 2'b01);

    check("q_aw_empty", exp_aw.size(), 0);
    check("q_w_empty", exp_w.size(), 0);
    check("q_ar_empty", exp_ar.size(), 0);
    check("q_b_empty", exp_b0.size() + exp_b1.size(), 0);
    check("q_r_empty", exp_r0.size() + exp_r1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
